// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the cached memory controller: FSM states, SPI
// command bytes, the full-word transfer size and a constant clog2 helper.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_HIT,
    ST_MISS,
    ST_DONE
  } state_t;

  localparam logic [2:0] NUM_BYTES_WORD = 3'd4;
  localparam logic [7:0] SPI_CMD_READ   = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE  = 8'h02;

  // Smallest r with 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_cache_dm.sv
// Direct-mapped read cache, one 32-bit word per line.
// Ports: lookup_index/lookup_tag -> lookup_hit_c/lookup_data_c (combinational),
//        fill_* writes a line and marks it valid, inval_* clears a matching
//        valid line, flush clears every valid bit (wins over a same-cycle fill).
module mem_cache_dm
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned LINES = 8,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned TAG_W = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] lookup_index,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             lookup_hit_c,
  output logic [31:0]      lookup_data_c,
  input  logic             fill_en,
  input  logic [IDX_W-1:0] fill_index,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [31:0]      fill_data,
  input  logic             inval_en,
  input  logic [IDX_W-1:0] inval_index,
  input  logic [TAG_W-1:0] inval_tag,
  input  logic             flush
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0]      data [LINES];

  assign lookup_hit_c  = valid[lookup_index] && (tags[lookup_index] == lookup_tag);
  assign lookup_data_c = data[lookup_index];

  // Valid bits: flush beats fill and invalidate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else begin
      if (inval_en && valid[inval_index] && (tags[inval_index] == inval_tag))
        valid[inval_index] <= 1'b0;
      if (fill_en)
        valid[fill_index] <= 1'b1;
    end
  end

  // Tag/data storage needs no reset; it is only read behind a valid bit.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[fill_index] <= fill_tag;
      data[fill_index] <= fill_data;
    end
  end

endmodule

// File: rtl/mem_external.sv
// SPI engine (mode 0): command byte, 24-bit address, then 1/2/4 data bytes,
// lowest address first, each byte MSB first. One SPI bit takes two clk cycles.
// addr[23]=0 selects flash on cs1, addr[23]=1 selects PSRAM on cs2.
// Ports: start (1-cycle) with is_write/num_bytes/addr/wdata -> done (1-cycle)
//        with rdata LSB-aligned; miso/sclk/mosi/cs1/cs2 to the devices.
module mem_external
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_write,
  input  logic [2:0]  num_bytes,
  input  logic [23:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        cs1,
  output logic        cs2
);

  logic        active;
  logic        phase;
  logic [62:0] tx;
  logic [31:0] rx;
  logic [31:0] rx_swap_c;
  logic [5:0]  bit_cnt;
  logic [5:0]  last_bit;
  logic [4:0]  shift_r;
  logic [7:0]  cmd_c;

  assign cmd_c     = is_write ? SPI_CMD_WRITE : SPI_CMD_READ;
  // First received byte lands in rx's top; reverse so it becomes bits [7:0].
  assign rx_swap_c = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      phase    <= 1'b0;
      tx       <= '0;
      rx       <= '0;
      bit_cnt  <= '0;
      last_bit <= '0;
      shift_r  <= '0;
      done     <= 1'b0;
      rdata    <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs1      <= 1'b1;
      cs2      <= 1'b1;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (start) begin
          active  <= 1'b1;
          phase   <= 1'b0;
          bit_cnt <= '0;
          rx      <= '0;
          tx      <= {cmd_c[6:0], addr, wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
          mosi    <= cmd_c[7];
          cs1     <= addr[23];
          cs2     <= ~addr[23];
          case (num_bytes)
            3'd4:    begin last_bit <= 6'd63; shift_r <= 5'd0;  end
            3'd2:    begin last_bit <= 6'd47; shift_r <= 5'd16; end
            default: begin last_bit <= 6'd39; shift_r <= 5'd24; end
          endcase
        end
      end else if (!phase) begin
        // Rising sclk: device samples mosi, we sample miso it set up earlier.
        sclk  <= 1'b1;
        phase <= 1'b1;
        if (bit_cnt >= 6'd32) rx <= {rx[30:0], miso};
      end else begin
        sclk  <= 1'b0;
        phase <= 1'b0;
        if (bit_cnt == last_bit) begin
          active <= 1'b0;
          cs1    <= 1'b1;
          cs2    <= 1'b1;
          mosi   <= 1'b0;
          done   <= 1'b1;
          rdata  <= rx_swap_c >> shift_r;
        end else begin
          bit_cnt <= bit_cnt + 6'd1;
          mosi    <= tx[62];
          tx      <= {tx[61:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/cached_mem_controller.sv
// External-memory front end: direct-mapped I/D read caches in front of the
// SPI engine, write-through with invalidate-on-store, flush, hit/miss counters.
// Ports: core side is_write/num_bytes/write_value/target_address/is_data_fetch/
//        start_request -> request_done/fetched_data; flush; hit_count/miss_count;
//        SPI side miso/sclk/mosi/cs1/cs2.
module cached_mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned LINES     = 8,
  parameter bit          ICACHE_EN = 1'b1,
  parameter bit          DCACHE_EN = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             miso,
  output logic             sclk,
  output logic             mosi,
  output logic             cs1,
  output logic             cs2,
  input  logic             is_write,
  input  logic [2:0]       num_bytes,
  input  logic [31:0]      write_value,
  input  logic [31:0]      target_address,
  input  logic             is_data_fetch,
  input  logic             start_request,
  output logic             request_done,
  output logic [31:0]      fetched_data,
  input  logic             flush,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned IDX_W = clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  state_t      state;
  logic        start_q, lat_write, lat_data, abort, flush_pend, done_r;
  logic [2:0]  lat_nb;
  logic [31:0] lat_addr, lat_wdata, data_r;
  logic        ext_done;
  logic [31:0] ext_rdata;
  logic        i_hit_c, d_hit_c;
  logic [31:0] i_data_c, d_data_c;
  logic        cacheable_c, lookup_hit_c, ext_start_c, fill_c, inval_c;
  logic [IDX_W-1:0] idx_c;
  logic [TAG_W-1:0] tag_c;
  logic        unused_addr_hi;

  assign idx_c          = lat_addr[IDX_W+1:2];
  assign tag_c          = lat_addr[ADDR_W-1:IDX_W+2];
  assign unused_addr_hi = ^lat_addr[31:24];

  assign cacheable_c  = !lat_write && (lat_nb == NUM_BYTES_WORD) && (lat_addr[1:0] == 2'b00)
                        && (lat_data ? DCACHE_EN : ICACHE_EN);
  assign lookup_hit_c = cacheable_c && (lat_data ? d_hit_c : i_hit_c);
  assign ext_start_c  = (state == ST_LOOKUP) && !lookup_hit_c;
  // A fill is dropped if the core gave up or a flush arrived during the miss.
  assign fill_c  = (state == ST_MISS) && ext_done && cacheable_c && start_request
                   && !abort && !flush_pend;
  assign inval_c = (state == ST_MISS) && ext_done && lat_write;

  assign request_done = done_r & start_request;
  assign fetched_data = start_request ? data_r : 32'd0;

  mem_cache_dm #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_icache (
    .clk(clk), .rst_n(rst_n),
    .lookup_index(idx_c), .lookup_tag(tag_c),
    .lookup_hit_c(i_hit_c), .lookup_data_c(i_data_c),
    .fill_en(fill_c && !lat_data), .fill_index(idx_c), .fill_tag(tag_c), .fill_data(ext_rdata),
    .inval_en(inval_c), .inval_index(idx_c), .inval_tag(tag_c),
    .flush(flush)
  );

  mem_cache_dm #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_dcache (
    .clk(clk), .rst_n(rst_n),
    .lookup_index(idx_c), .lookup_tag(tag_c),
    .lookup_hit_c(d_hit_c), .lookup_data_c(d_data_c),
    .fill_en(fill_c && lat_data), .fill_index(idx_c), .fill_tag(tag_c), .fill_data(ext_rdata),
    .inval_en(inval_c), .inval_index(idx_c), .inval_tag(tag_c),
    .flush(flush)
  );

  mem_external u_ext (
    .clk(clk), .rst_n(rst_n),
    .start(ext_start_c), .is_write(lat_write), .num_bytes(lat_nb),
    .addr(lat_addr[23:0]), .wdata(lat_wdata),
    .done(ext_done), .rdata(ext_rdata),
    .miso(miso), .sclk(sclk), .mosi(mosi), .cs1(cs1), .cs2(cs2)
  );

  // Request FSM and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      start_q    <= 1'b0;
      lat_write  <= 1'b0;
      lat_data   <= 1'b0;
      lat_nb     <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      abort      <= 1'b0;
      flush_pend <= 1'b0;
      done_r     <= 1'b0;
      data_r     <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      start_q <= start_request;
      case (state)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start_request && !start_q) begin
            lat_write <= is_write;
            lat_data  <= is_data_fetch;
            lat_nb    <= num_bytes;
            lat_addr  <= target_address;
            lat_wdata <= write_value;
            state     <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          flush_pend <= flush;
          abort      <= !start_request;
          if (lookup_hit_c) begin
            state  <= ST_HIT;
            done_r <= 1'b1;
            data_r <= lat_data ? d_data_c : i_data_c;
            if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
          end else begin
            state <= ST_MISS;
            if (cacheable_c && (miss_count != '1)) miss_count <= miss_count + CNT_W'(1);
          end
        end
        ST_MISS: begin
          if (flush) flush_pend <= 1'b1;
          if (!start_request) abort <= 1'b1;
          if (ext_done) begin
            data_r <= ext_rdata;
            if (abort || !start_request) begin
              state <= ST_IDLE;
            end else begin
              done_r <= 1'b1;
              state  <= ST_DONE;
            end
          end
        end
        ST_HIT, ST_DONE: begin
          if (!start_request) begin
            done_r <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cached_mem_controller.sv
// Self-checking bench: SPI device model with its own byte memory, plus a
// behavioural model (reference memory and per-cache valid/tag tables).
module tb_cached_mem_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miso = 1'b0;
  logic        sclk, mosi, cs1, cs2;
  logic        is_write = 1'b0;
  logic [2:0]  num_bytes = 3'd4;
  logic [31:0] write_value = '0;
  logic [31:0] target_address = '0;
  logic        is_data_fetch = 1'b0;
  logic        start_request = 1'b0;
  logic        request_done;
  logic [31:0] fetched_data;
  logic        flush = 1'b0;
  logic [15:0] hit_count, miss_count;

  int checks = 0;
  int failures = 0;

  cached_mem_controller dut (
    .clk(clk), .rst_n(rst_n), .miso(miso), .sclk(sclk), .mosi(mosi),
    .cs1(cs1), .cs2(cs2), .is_write(is_write), .num_bytes(num_bytes),
    .write_value(write_value), .target_address(target_address),
    .is_data_fetch(is_data_fetch), .start_request(start_request),
    .request_done(request_done), .fetched_data(fetched_data), .flush(flush),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- memories ----------------
  logic [7:0] slave_mem [int unsigned];
  logic [7:0] ref_mem   [int unsigned];

  function automatic logic [7:0] def_byte(input int unsigned a);
    return 8'((a * 37) + (a >> 8) + 90);
  endfunction

  function automatic logic [7:0] rd_slave(input int unsigned a);
    int unsigned k;
    k = a & 32'h00FF_FFFF;
    return slave_mem.exists(k) ? slave_mem[k] : def_byte(k);
  endfunction

  function automatic logic [7:0] rd_ref(input int unsigned a);
    int unsigned k;
    k = a & 32'h00FF_FFFF;
    return ref_mem.exists(k) ? ref_mem[k] : def_byte(k);
  endfunction

  // ---------------- SPI device model ----------------
  logic        cs_n;
  int unsigned sl_cnt = 0;
  logic [31:0] sl_sh = '0;
  logic [7:0]  sl_cmd = '0;
  logic [23:0] sl_addr = '0;
  int unsigned txn_cs1 = 0;
  int unsigned txn_cs2 = 0;

  assign cs_n = cs1 & cs2;

  always @(negedge cs_n) begin
    sl_cnt = 0;
    miso   = 1'b0;
    if (!cs1) txn_cs1++;
    if (!cs2) txn_cs2++;
  end

  always @(posedge sclk) begin
    if (!cs_n) begin
      sl_sh = {sl_sh[30:0], mosi};
      sl_cnt++;
      if (sl_cnt == 32) begin
        sl_cmd  = sl_sh[31:24];
        sl_addr = sl_sh[23:0];
      end else if (sl_cnt > 32 && sl_cmd == 8'h02 && ((sl_cnt - 32) % 8) == 0) begin
        slave_mem[(32'(sl_addr) + (sl_cnt - 32) / 8 - 1) & 32'h00FF_FFFF] = sl_sh[7:0];
      end
    end
  end

  always @(negedge sclk) begin
    logic [7:0] b;
    if (!cs_n && sl_cnt >= 32 && sl_cmd == 8'h03) begin
      b    = rd_slave(32'(sl_addr) + (sl_cnt - 32) / 8);
      miso = b[7 - ((sl_cnt - 32) % 8)];
    end
  end

  // ---------------- cache reference model ----------------
  bit          mv [2][8];
  logic [18:0] mt [2][8];
  int unsigned m_hits = 0;
  int unsigned m_miss = 0;

  function automatic void model_clear();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 8; i++) mv[c][i] = 1'b0;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_clear();
  endtask

  // One complete core transaction; flush_at >= 5 pulses flush during the miss.
  task automatic do_access(input bit wr, input logic [2:0] nb, input logic [31:0] addr,
                           input logic [31:0] wd, input bit isd, input int flush_at,
                           input string tag);
    bit          cach, exp_hit, flushed;
    int          c, idx;
    int unsigned c1, c2;
    logic [31:0] expv;
    logic [18:0] tg;
    cach    = !wr && nb == 3'd4 && addr[1:0] == 2'b00;
    idx     = int'(addr[4:2]);
    tg      = addr[23:5];
    exp_hit = cach && mv[isd][idx] && mt[isd][idx] == tg;
    expv    = '0;
    for (int k = 0; k < int'(nb); k++) expv |= 32'(rd_ref(addr + 32'(k))) << (8 * k);
    c1 = txn_cs1;
    c2 = txn_cs2;
    is_write       = wr;
    num_bytes      = nb;
    target_address = addr;
    write_value    = wd;
    is_data_fetch  = isd;
    start_request  = 1'b1;
    c       = 0;
    flushed = 1'b0;
    do begin
      @(posedge clk); #1;
      c++;
      if (c == flush_at) begin
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        c++;
        flushed = 1'b1;
      end
    end while (!request_done && c < 1000);
    check({tag, "_done"}, 64'(request_done), 64'd1);
    if (exp_hit) begin
      check({tag, "_hit_latency"}, 64'(c), 64'd2);
      check({tag, "_hit_no_spi"}, 64'((txn_cs1 - c1) + (txn_cs2 - c2)), 64'd0);
    end else begin
      check({tag, "_cs1_txn"}, 64'(txn_cs1 - c1), addr[23] ? 64'd0 : 64'd1);
      check({tag, "_cs2_txn"}, 64'(txn_cs2 - c2), addr[23] ? 64'd1 : 64'd0);
    end
    if (!wr) check({tag, "_data"}, 64'(fetched_data), 64'(expv));
    start_request = 1'b0;
    #1;
    check({tag, "_done_drop"}, 64'(request_done), 64'd0);
    check({tag, "_data_zero"}, 64'(fetched_data), 64'd0);
    @(posedge clk); #1;
    if (wr) begin
      for (int k = 0; k < int'(nb); k++)
        ref_mem[(addr + 32'(k)) & 32'h00FF_FFFF] = wd[8*k +: 8];
      for (int cc = 0; cc < 2; cc++)
        if (mv[cc][idx] && mt[cc][idx] == tg) mv[cc][idx] = 1'b0;
    end
    if (flushed) model_clear();
    if (exp_hit) m_hits++;
    else if (cach) begin
      m_miss++;
      if (!flushed) begin
        mv[isd][idx] = 1'b1;
        mt[isd][idx] = tg;
      end
    end
    check({tag, "_hit_count"}, 64'(hit_count), 64'(m_hits));
    check({tag, "_miss_count"}, 64'(miss_count), 64'(m_miss));
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  nb;
    int          r;
    bit          isd;
    model_clear();
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 64'(request_done), 64'd0);
    check("rst_data", 64'(fetched_data), 64'd0);
    check("rst_cs1", 64'(cs1), 64'd1);
    check("rst_cs2", 64'(cs2), 64'd1);
    check("rst_sclk", 64'(sclk), 64'd0);
    check("rst_mosi", 64'(mosi), 64'd0);
    check("rst_hits", 64'(hit_count), 64'd0);
    check("rst_miss", 64'(miss_count), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. cold read then hit
    do_access(1'b0, 3'd4, 32'h0000_0100, '0, 1'b1, -1, "t1_cold");
    check("t1_miss_is_1", 64'(miss_count), 64'd1);
    do_access(1'b0, 3'd4, 32'h0000_0100, '0, 1'b1, -1, "t1_rehit");
    check("t1_hit_is_1", 64'(hit_count), 64'd1);

    // 2. store to cached word, load misses and returns the new value, then hits
    do_access(1'b1, 3'd4, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, -1, "t2_store");
    do_access(1'b0, 3'd4, 32'h0000_0100, '0, 1'b1, -1, "t2_load");
    check("t2_value", 64'(ref_mem[32'h100]) | (64'(ref_mem[32'h103]) << 24), 64'hDE00_00EF);
    do_access(1'b0, 3'd4, 32'h0000_0100, '0, 1'b1, -1, "t2_refilled");

    // 3. aliasing on index 0
    do_access(1'b0, 3'd4, 32'h0000_0020, '0, 1'b1, -1, "t3_a20");
    do_access(1'b0, 3'd4, 32'h0000_0040, '0, 1'b1, -1, "t3_a40");
    do_access(1'b0, 3'd4, 32'h0000_0040, '0, 1'b1, -1, "t3_a40_hit");
    do_access(1'b0, 3'd4, 32'h0000_0020, '0, 1'b1, -1, "t3_a20_miss");

    // 4. sub-word reads are never cached
    do_access(1'b0, 3'd1, 32'h0000_0101, '0, 1'b1, -1, "t4_byte");
    do_access(1'b0, 3'd2, 32'h0000_0100, '0, 1'b1, -1, "t4_half");

    // 5. flush while idle and during a miss
    do_access(1'b0, 3'd4, 32'h0000_0180, '0, 1'b0, -1, "t5_fill");
    do_flush();
    do_access(1'b0, 3'd4, 32'h0000_0180, '0, 1'b0, -1, "t5_after_flush");
    do_access(1'b0, 3'd4, 32'h0080_01C0, '0, 1'b1, 20, "t5_flush_mid");
    do_access(1'b0, 3'd4, 32'h0080_01C0, '0, 1'b1, -1, "t5_still_miss");

    // 6. reset in the middle of a miss
    do_access(1'b0, 3'd4, 32'h0000_0200, '0, 1'b1, -1, "t6_fill");
    is_write = 1'b0; num_bytes = 3'd4; target_address = 32'h0000_0300; is_data_fetch = 1'b1;
    start_request = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_cs1", 64'(cs1), 64'd1);
    check("t6_cs2", 64'(cs2), 64'd1);
    check("t6_done", 64'(request_done), 64'd0);
    check("t6_hits", 64'(hit_count), 64'd0);
    check("t6_miss", 64'(miss_count), 64'd0);
    start_request = 1'b0;
    model_clear();
    m_hits = 0;
    m_miss = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_access(1'b0, 3'd4, 32'h0000_0200, '0, 1'b1, -1, "t6_post_reset");

    // Randomized mix against the model
    for (int i = 0; i < 200; i++) begin
      r   = int'($urandom_range(0, 99));
      isd = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 1) ? 32'h0080_0000 : 32'h0) | (32'($urandom_range(0, 31)) << 2);
      if ($urandom_range(0, 3) == 0) a |= 32'($urandom_range(1, 255)) << 24;
      if (r < 5) begin
        do_flush();
      end else if (r < 10) begin
        do_access(1'b0, 3'd4, a, '0, isd, int'($urandom_range(5, 60)), "rnd_flush_rd");
      end else if (r < 65) begin
        do_access(1'b0, 3'd4, a, '0, isd, -1, "rnd_rd");
      end else if (r < 82) begin
        case ($urandom_range(0, 2))
          0:       nb = 3'd1;
          1:       nb = 3'd2;
          default: nb = 3'd4;
        endcase
        if (nb == 3'd1) a |= 32'($urandom_range(0, 3));
        else if (nb == 3'd2) a |= 32'($urandom_range(0, 1)) << 1;
        do_access(1'b1, nb, a, $urandom, isd, -1, "rnd_wr");
      end else begin
        case ($urandom_range(0, 2))
          0:       nb = 3'd1;
          1:       nb = 3'd2;
          default: nb = 3'd4;
        endcase
        a |= 32'($urandom_range(0, 3));
        do_access(1'b0, nb, a, '0, isd, -1, "rnd_small_rd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
